// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - result codes, FSM states and cascade mapping for the digit-serial comparator.
package cmp_pkg;

  localparam logic [2:0] CMP_LT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_GT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Only one-hot legal codes pass; anything else collapses to "equal, no cascade verdict".
  function automatic logic [2:0] cmp_map(input logic [2:0] code);
    case (code)
      CMP_LT, CMP_EQ, CMP_GT: cmp_map = code;
      default:                cmp_map = CMP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// rtl/cmp_digit.sv - combinational DIGIT-bit magnitude compare with cascade in/out.
module cmp_digit
  import cmp_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic [2:0]       casc_in,
  output logic [2:0]       casc_out
);

  always_comb begin
    if (a > b)      casc_out = CMP_GT;
    else if (a < b) casc_out = CMP_LT;
    else            casc_out = casc_in;
  end

endmodule

// File: rtl/seq_magnitude_compare.sv
// rtl/seq_magnitude_compare.sv - MSB-first digit-serial magnitude comparator, valid/ready on both sides.
// COMPARE_EARLY_EXIT_EN: stop on first unequal digit; otherwise constant NDIG-cycle latency.
module seq_magnitude_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iSigned,
  input  logic [2:0]       iData,
  output logic             oValid,
  input  logic             iReady,
  output logic [2:0]       oData,
  output logic             oBusy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_width
    $error("seq_magnitude_compare: WIDTH must be a multiple of DIGIT");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        casc_q, casc_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [2:0]        data_q, data_d;
  logic              valid_q, valid_d, ready_q, ready_d, busy_q, busy_d;
`ifndef COMPARE_EARLY_EXIT_EN
  logic              decided_q, decided_d;
  logic [2:0]        pend_q, pend_d;
  logic [2:0]        res;
`endif

  logic [WIDTH-1:0]  sign_mask;
  logic [DIGIT-1:0]  a_dig, b_dig;
  logic [2:0]        dig_casc, dig_out;

  // Flipping the MSB maps two's-complement order onto unsigned order.
  assign sign_mask = {iSigned, {(WIDTH-1){1'b0}}};

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  // The cascade code only matters on the last digit; earlier digits report plain EQ.
  assign dig_casc = (idx_q == '0) ? cmp_map(casc_q) : CMP_EQ;

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_dig),
    .b        (b_dig),
    .casc_in  (dig_casc),
    .casc_out (dig_out)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    casc_d  = casc_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    ready_d = ready_q;
    busy_d  = busy_q;
`ifndef COMPARE_EARLY_EXIT_EN
    decided_d = decided_q;
    pend_d    = pend_q;
    res       = decided_q ? pend_q : dig_out;
`endif
    case (state_q)
      IDLE: begin
        if (iValid) begin
          a_d     = iData_a ^ sign_mask;
          b_d     = iData_b ^ sign_mask;
          casc_d  = iData;
          idx_d   = IDXW'(NDIG - 1);
          state_d = RUN;
          ready_d = 1'b0;
          busy_d  = 1'b1;
`ifndef COMPARE_EARLY_EXIT_EN
          decided_d = 1'b0;
          pend_d    = CMP_NONE;
`endif
        end
      end
      RUN: begin
`ifdef COMPARE_EARLY_EXIT_EN
        if (idx_q == '0 || dig_out != CMP_EQ) begin
          data_d  = dig_out;
          state_d = DONE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`else
        if (idx_q == '0) begin
          data_d  = res;
          state_d = DONE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          if (!decided_q && dig_out != CMP_EQ) begin
            decided_d = 1'b1;
            pend_d    = dig_out;
          end
          idx_d = idx_q - 1'b1;
        end
`endif
      end
      DONE: begin
        if (iReady) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= '0;
      idx_q   <= '0;
      data_q  <= CMP_NONE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifndef COMPARE_EARLY_EXIT_EN
      decided_q <= 1'b0;
      pend_q    <= CMP_NONE;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifndef COMPARE_EARLY_EXIT_EN
      decided_q <= decided_d;
      pend_q    <= pend_d;
`endif
    end
  end

  assign oReady = ready_q;
  assign oValid = valid_q;
  assign oData  = data_q;
  assign oBusy  = busy_q;

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// tb/tb_seq_magnitude_compare.sv - directed table-driven bench for seq_magnitude_compare (16/4 and 8/8).
module tb_seq_magnitude_compare;

  logic        clk;
  logic        rst_n;
  logic        valid_in, ready_out, valid_out, ready_in, sgn, busy;
  logic [15:0] da, db;
  logic [2:0]  casc, res;

  logic        v8_in, r8_out, v8_out, r8_in, s8, busy8;
  logic [7:0]  a8, b8;
  logic [2:0]  c8, res8;

  int checks = 0;
  int errors = 0;

  seq_magnitude_compare #(.WIDTH(16), .DIGIT(4)) dut (
    .iClk(clk), .iRst_n(rst_n), .iValid(valid_in), .oReady(ready_out),
    .iData_a(da), .iData_b(db), .iSigned(sgn), .iData(casc),
    .oValid(valid_out), .iReady(ready_in), .oData(res), .oBusy(busy)
  );

  seq_magnitude_compare #(.WIDTH(8), .DIGIT(8)) dut8 (
    .iClk(clk), .iRst_n(rst_n), .iValid(v8_in), .oReady(r8_out),
    .iData_a(a8), .iData_b(b8), .iSigned(s8), .iData(c8),
    .oValid(v8_out), .iReady(r8_in), .oData(res8), .oBusy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [2:0]  c;
    logic [2:0]  exp;
    int          lat_early;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one request, returns after the result is seen (and acknowledged if ack).
  task automatic run_req(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [2:0] c, input logic [2:0] exp,
                         input int lat_early, input bit ack);
    int lat;
    int exp_lat;
`ifdef COMPARE_EARLY_EXIT_EN
    exp_lat = lat_early;
`else
    exp_lat = 4;
`endif
    @(negedge clk);
    valid_in = 1'b1; da = a; db = b; sgn = s; casc = c;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    da = ~a; db = ~b; sgn = ~s; casc = 3'b111;
    chk({name, "_busy"}, busy, 1);
    chk({name, "_ready_low"}, ready_out, 0);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        lat = n;
        break;
      end
    end
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_data"}, res, exp);
    if (ack) begin
      @(negedge clk);
      ready_in = 1'b1;
      @(posedge clk);
      #1;
      ready_in = 1'b0;
      chk({name, "_valid_clr"}, valid_out, 0);
      chk({name, "_ready_back"}, ready_out, 1);
    end
  endtask

  initial begin
    vecs[0]  = '{16'h1234, 16'h1235, 1'b0, 3'b010, 3'b100, 4};
    vecs[1]  = '{16'h9000, 16'h1FFF, 1'b0, 3'b010, 3'b001, 1};
    vecs[2]  = '{16'h9000, 16'h1FFF, 1'b1, 3'b010, 3'b100, 1};
    vecs[3]  = '{16'hABCD, 16'hABCD, 1'b0, 3'b100, 3'b100, 4};
    vecs[4]  = '{16'hABCD, 16'hABCD, 1'b0, 3'b001, 3'b001, 4};
    vecs[5]  = '{16'hABCD, 16'hABCD, 1'b0, 3'b010, 3'b010, 4};
    vecs[6]  = '{16'hABCD, 16'hABCD, 1'b0, 3'b011, 3'b000, 4};
    vecs[7]  = '{16'h0000, 16'hFFFF, 1'b1, 3'b010, 3'b001, 1};
    vecs[8]  = '{16'h1299, 16'h1310, 1'b0, 3'b010, 3'b100, 2};
    vecs[9]  = '{16'h8000, 16'h8000, 1'b1, 3'b001, 3'b001, 4};
    vecs[10] = '{16'hFFFF, 16'hFFFE, 1'b1, 3'b100, 3'b001, 4};

    rst_n = 1'b0;
    valid_in = 1'b0; ready_in = 1'b0; da = '0; db = '0; sgn = 1'b0; casc = 3'b010;
    v8_in = 1'b0; r8_in = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; c8 = 3'b010;
    #12;
    chk("rst_ready", ready_out, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", res, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_req($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c,
              vecs[i].exp, vecs[i].lat_early, 1'b1);

    // Consumer stalls; a second request must be ignored while the result is held.
    run_req("hs", 16'h9000, 16'h1FFF, 1'b0, 3'b010, 3'b001, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_in = 1'b1; da = 16'h0001; db = 16'h0002; sgn = 1'b0; casc = 3'b010;
      @(posedge clk);
      #1;
      chk($sformatf("hs_hold_valid%0d", i), valid_out, 1);
      chk($sformatf("hs_hold_data%0d", i), res, 3'b001);
      chk($sformatf("hs_hold_ready%0d", i), ready_out, 0);
    end
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    ready_in = 1'b0;
    chk("hs_release_valid", valid_out, 0);
    chk("hs_release_ready", ready_out, 1);
    run_req("hs_next", 16'h1234, 16'h1235, 1'b0, 3'b010, 3'b100, 4, 1'b1);

    // Reset pulse in the middle of RUN.
    @(negedge clk);
    valid_in = 1'b1; da = 16'h1234; db = 16'h1235; sgn = 1'b0; casc = 3'b010;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", valid_out, 0);
    chk("mid_rst_data", res, 0);
    chk("mid_rst_ready", ready_out, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_req("post_rst", 16'h9000, 16'h1FFF, 1'b1, 3'b010, 3'b100, 1, 1'b1);

    // Single-digit instance: exactly one RUN cycle.
    for (int k = 0; k < 2; k++) begin
      int lat8;
      @(negedge clk);
      v8_in = 1'b1; a8 = 8'h7F; b8 = 8'h80; s8 = (k == 0); c8 = 3'b010;
      @(posedge clk);
      #1;
      v8_in = 1'b0;
      lat8 = 0;
      for (int n = 1; n <= 10; n++) begin
        @(posedge clk);
        #1;
        if (v8_out) begin
          lat8 = n;
          break;
        end
      end
      chk($sformatf("w8_lat%0d", k), lat8, 1);
      chk($sformatf("w8_data%0d", k), res8, (k == 0) ? 3'b001 : 3'b100);
      @(negedge clk);
      r8_in = 1'b1;
      @(posedge clk);
      #1;
      r8_in = 1'b0;
      chk($sformatf("w8_ready%0d", k), r8_out, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_compare.md
Name: seq_magnitude_compare

Overview:
- Parametrised, digit-serial magnitude comparator; successor to the team's 4/8-bit cascaded comparators.
- Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, with unsigned or signed mode, a cascade input for chaining, and early termination.
- Uses a valid/ready handshake on both input and result.
- Sits in datapaths where wide compares must not sit in a single-cycle combinational path.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT (elaboration error otherwise).
- DIGIT, 4, bits compared per cycle; NDIG = WIDTH/DIGIT.

Ports:
- iClk  input  1  clock, rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iValid  input  1  request valid.
- oReady  output  1  block can accept a request.
- iData_a  input  WIDTH  operand A.
- iData_b  input  WIDTH  operand B.
- iSigned  input  1  1 = two's-complement compare; captured with operands.
- iData  input  3  cascade result used when A==B: 100 lt, 010 eq, 001 gt; captured with operands.
- oValid  output  1  result valid.
- iReady  input  1  consumer accepts result.
- oData  output  3  result: 100 A<B, 010 A==B (cascade eq), 001 A>B, 000 equal with invalid cascade.
- oBusy  output  1  compare in progress (RUN state).

Behaviour:
- Reset (async assert, sync deassert by system): state IDLE; oReady=1, oValid=0, oData=000, oBusy=0; captured registers cleared.
- FSM states:
  - IDLE: oReady=1. When iValid&oReady, capture A, B, iSigned, iData; digit index=NDIG-1; go to RUN.
  - RUN: oBusy=1, oReady=0. Each cycle compare digit[idx] of A vs B.
    - A>B digit -> result 001, go to DONE.
    - A<B digit -> result 100, go to DONE.
    - Equal and idx==0 -> result = cascade map (100/010/001 pass through, anything else 000), go to DONE.
    - Equal otherwise -> idx-1, stay in RUN.
  - DONE: oValid=1, oData holds result stable. When iReady, go to IDLE, oValid=0. oData retains its last value until the next result is written.
- Signed mode: invert bit DIGIT-1 of the top digit of both operands before comparing; lower digits are unsigned.
- Latency: the accept edge is cycle 0. The result is registered at the end of RUN cycle k, where k = digits examined (1..NDIG); oValid is high in cycle k+1.
- WIDTH==DIGIT: exactly one RUN cycle.
- iValid while not IDLE is ignored. Operand changes after capture have no effect.
- iReady already high on oValid's first cycle: one-cycle DONE, back in IDLE next cycle.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE; the result is discarded.
- No back-to-back accept in DONE: one request in flight at a time.

Optional Feature:
- Macro: COMPARE_EARLY_EXIT_EN.
- Defined: RUN exits on the first unequal digit; latency varies from 1 to NDIG.
- Undefined: RUN always consumes all NDIG digits. The first unequal digit (MSB-most) is latched in a sticky decided flag and later digits are ignored. Latency is constant NDIG, which gives data-independent timing. Result values are identical in both builds.

Decomposition:
- Package cmp_pkg:
  - constants CMP_LT=3'b100, CMP_EQ=3'b010, CMP_GT=3'b001, CMP_NONE=3'b000;
  - state enum {IDLE, RUN, DONE};
  - function mapping a cascade code to a legal result.
- Sub-module cmp_digit: combinational DIGIT-bit compare with cascade in/out, same encoding as the existing 4-bit comparator, parametrised by DIGIT. The top-level instantiates one and muxes the digit by idx.

Test Plan (WIDTH=16, DIGIT=4 unless noted):
- Unsigned, A=16'h1234, B=16'h1235, iData=010 -> oData=100. With early exit, oValid in cycle 5 (4 digits). Without early exit, also cycle 5.
- A=16'h9000, B=16'h1FFF, unsigned -> 001, oValid cycle 2 with early exit, cycle 5 without. The same operands with iSigned=1 -> 100 (negative < positive).
- A=B=16'hABCD with iData=100, 001, 010, 011 -> oData 100, 001, 010, 000 respectively, each after 4 digits.
- Handshake: iReady held 0 for 3 cycles -> oValid and oData stable, oReady=0, second iValid ignored. Then iReady=1 -> IDLE next cycle, and a new request is accepted.
- Reset pulse iRst_n=0 during RUN (cycle 2) -> same-cycle oBusy=0, oValid=0, oData=000, oReady=1. Post-reset request completes normally.
- WIDTH=8, DIGIT=8, A=8'h7F, B=8'h80, iSigned=1 -> 001 with oValid in cycle 2.
